// File: rtl/acc_pkg.sv
// Shared opcodes and sizing helpers for the accumulator/stack unit.
package acc_pkg;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_SHL  = 3'd4;
    localparam logic [2:0] OP_SHR  = 3'd5;
    localparam logic [2:0] OP_PUSH = 3'd6;
    localparam logic [2:0] OP_POP  = 3'd7;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/acc_lifo.sv
// DEPTH x WIDTH save stack with occupancy tracking and illegal-access pulse.
module acc_lifo
    import acc_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              wdata,
    output logic [WIDTH-1:0]              rdata,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic                          full,
    output logic                          empty,
    output logic                          err
);

    localparam int unsigned CW = cnt_width(DEPTH);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    top_idx;
    logic             err_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign top_idx = count_q - CW'(1);
    assign rdata   = mem_q[top_idx[IW-1:0]];
    assign count   = count_q;
    assign err     = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= (push && full) || (pop && empty);
            if (do_push) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop) begin
                count_q <= top_idx;
            end
        end
    end

    // Entries are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[count_q[IW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/acc_stack_unit.sv
// Accumulator with add/sub/shift datapath, registered C/V flags and a LIFO save stack.
module acc_stack_unit
    import acc_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [WIDTH-1:0]              data_in,
    input  logic [2:0]                    op,
    input  logic                          op_en,
    output logic [WIDTH-1:0]              acc_out,
    output logic                          zero_flag,
    output logic                          carry_flag,
    output logic                          neg_flag,
    output logic                          ovf_flag,
    output logic [cnt_width(DEPTH)-1:0]   stk_count,
    output logic                          stk_full,
    output logic                          stk_empty,
    output logic                          stk_err
);

    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic             c_q, c_d;
    logic             v_q, v_d;
    logic             push, pop;
    logic [WIDTH-1:0] stk_rdata;
    logic [WIDTH:0]   sum, diff;

    // Bit WIDTH of the extended result is the carry out / borrow.
    assign sum  = {1'b0, acc_q} + {1'b0, data_in};
    assign diff = {1'b0, acc_q} - {1'b0, data_in};

    always_comb begin
        acc_d = acc_q;
        c_d   = c_q;
        v_d   = v_q;
        push  = 1'b0;
        pop   = 1'b0;
        if (op_en) begin
            case (op)
                OP_LOAD: acc_d = data_in;
                OP_ADD: begin
                    {c_d, acc_d} = sum;
                    v_d = (acc_q[MSB] == data_in[MSB]) && (sum[MSB] != acc_q[MSB]);
                end
                OP_SUB: begin
                    {c_d, acc_d} = diff;
                    v_d = (acc_q[MSB] != data_in[MSB]) && (diff[MSB] != acc_q[MSB]);
                end
                OP_SHL: begin
                    acc_d = {acc_q[MSB-1:0], 1'b0};
                    c_d   = acc_q[MSB];
                    v_d   = 1'b0;
                end
                OP_SHR: begin
                    acc_d = {1'b0, acc_q[MSB:1]};
                    c_d   = acc_q[0];
                    v_d   = 1'b0;
                end
                OP_PUSH: push = 1'b1;
                OP_POP: begin
                    pop = 1'b1;
                    if (!stk_empty) begin
                        acc_d = stk_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            c_q   <= 1'b0;
            v_q   <= 1'b0;
        end else begin
            acc_q <= acc_d;
            c_q   <= c_d;
            v_q   <= v_d;
        end
    end

    acc_lifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (acc_q),
        .rdata (stk_rdata),
        .count (stk_count),
        .full  (stk_full),
        .empty (stk_empty),
        .err   (stk_err)
    );

    assign acc_out    = acc_q;
    assign zero_flag  = (acc_q == '0);
    assign neg_flag   = acc_q[MSB];
    assign carry_flag = c_q;
    assign ovf_flag   = v_q;

endmodule

// File: tb/tb_acc_stack_unit.sv
// Directed bench for acc_stack_unit (WIDTH=8, DEPTH=4) with hand-computed expectations.
module tb_acc_stack_unit;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 4;
    localparam int unsigned CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic [2:0]    op = 3'd0;
    logic          op_en = 1'b0;
    logic [W-1:0]  acc_out;
    logic          zero_flag, carry_flag, neg_flag, ovf_flag;
    logic [CW-1:0] stk_count;
    logic          stk_full, stk_empty, stk_err;

    int errors = 0;
    int checks = 0;

    acc_stack_unit #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .op         (op),
        .op_en      (op_en),
        .acc_out    (acc_out),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag),
        .neg_flag   (neg_flag),
        .ovf_flag   (ovf_flag),
        .stk_count  (stk_count),
        .stk_full   (stk_full),
        .stk_empty  (stk_empty),
        .stk_err    (stk_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one op for one cycle, then sample 1 time unit after the edge.
    task automatic exec(input logic [2:0] o, input logic [W-1:0] d);
        op      = o;
        data_in = d;
        op_en   = 1'b1;
        @(posedge clk);
        #1;
        op_en   = 1'b0;
        op      = 3'd0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #23;
        check("rst_acc", acc_out, 8'h00);
        check("rst_z", zero_flag, 1);
        check("rst_n_flag", neg_flag, 0);
        check("rst_c", carry_flag, 0);
        check("rst_v", ovf_flag, 0);
        check("rst_cnt", stk_count, 0);
        check("rst_empty", stk_empty, 1);
        check("rst_full", stk_full, 0);
        check("rst_err", stk_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        // LOAD
        exec(3'd1, 8'h00);
        check("ld00_acc", acc_out, 8'h00);
        check("ld00_z", zero_flag, 1);
        exec(3'd1, 8'h80);
        check("ld80_acc", acc_out, 8'h80);
        check("ld80_n", neg_flag, 1);
        check("ld80_z", zero_flag, 0);
        check("ld80_c", carry_flag, 0);
        check("ld80_v", ovf_flag, 0);

        // ADD
        exec(3'd1, 8'h7F);
        exec(3'd2, 8'h01);
        check("add1_acc", acc_out, 8'h80);
        check("add1_v", ovf_flag, 1);
        check("add1_c", carry_flag, 0);
        exec(3'd2, 8'h80);
        check("add2_acc", acc_out, 8'h00);
        check("add2_c", carry_flag, 1);
        check("add2_v", ovf_flag, 1);
        check("add2_z", zero_flag, 1);

        // SUB; LOAD leaves C/V untouched
        exec(3'd1, 8'h05);
        check("ld05_c_hold", carry_flag, 1);
        check("ld05_v_hold", ovf_flag, 1);
        exec(3'd3, 8'h07);
        check("sub1_acc", acc_out, 8'hFE);
        check("sub1_c", carry_flag, 1);
        check("sub1_n", neg_flag, 1);
        check("sub1_v", ovf_flag, 0);
        exec(3'd3, 8'hFE);
        check("sub2_acc", acc_out, 8'h00);
        check("sub2_c", carry_flag, 0);
        check("sub2_z", zero_flag, 1);
        exec(3'd1, 8'h80);
        exec(3'd3, 8'h01);
        check("sub3_acc", acc_out, 8'h7F);
        check("sub3_v", ovf_flag, 1);
        check("sub3_c", carry_flag, 0);

        // Shifts
        exec(3'd1, 8'h81);
        exec(3'd4, 8'h00);
        check("shl_acc", acc_out, 8'h02);
        check("shl_c", carry_flag, 1);
        check("shl_v", ovf_flag, 0);
        exec(3'd5, 8'h00);
        check("shr1_acc", acc_out, 8'h01);
        check("shr1_c", carry_flag, 0);
        exec(3'd5, 8'h00);
        check("shr2_acc", acc_out, 8'h00);
        check("shr2_c", carry_flag, 1);

        // op_en=0 and NOP both hold
        exec(3'd1, 8'h10);
        op = 3'd2; data_in = 8'h05; op_en = 1'b0;
        idle();
        op = 3'd0;
        check("open0_hold", acc_out, 8'h10);
        exec(3'd0, 8'h33);
        check("nop_hold", acc_out, 8'h10);
        check("nop_err", stk_err, 0);

        // Fill the stack
        exec(3'd1, 8'h11); exec(3'd6, 8'h00);
        exec(3'd1, 8'h22); exec(3'd6, 8'h00);
        exec(3'd1, 8'h33); exec(3'd6, 8'h00);
        check("push3_cnt", stk_count, 3);
        check("push3_full", stk_full, 0);
        exec(3'd1, 8'h44); exec(3'd6, 8'h00);
        check("push4_cnt", stk_count, 4);
        check("push4_full", stk_full, 1);
        check("push4_acc", acc_out, 8'h44);
        exec(3'd1, 8'h55);
        exec(3'd6, 8'h00);
        check("ovfpush_err", stk_err, 1);
        check("ovfpush_cnt", stk_count, 4);
        check("ovfpush_acc", acc_out, 8'h55);
        idle();
        check("ovfpush_err_clr", stk_err, 0);

        // Drain: the overflow push must not have clobbered the top entry
        exec(3'd7, 8'h00);
        check("pop1_acc", acc_out, 8'h44);
        check("pop1_cnt", stk_count, 3);
        check("pop1_err", stk_err, 0);
        exec(3'd7, 8'h00);
        check("pop2_acc", acc_out, 8'h33);
        exec(3'd7, 8'h00);
        check("pop3_acc", acc_out, 8'h22);
        exec(3'd7, 8'h00);
        check("pop4_acc", acc_out, 8'h11);
        check("pop4_empty", stk_empty, 1);
        check("pop4_cnt", stk_count, 0);
        check("pop4_c_hold", carry_flag, 1);
        check("pop4_v_hold", ovf_flag, 0);
        exec(3'd7, 8'h00);
        check("undpop_err", stk_err, 1);
        check("undpop_acc", acc_out, 8'h11);
        check("undpop_cnt", stk_count, 0);
        idle();
        check("undpop_err_clr", stk_err, 0);

        // Back-to-back PUSH then POP
        exec(3'd1, 8'h5A);
        exec(3'd6, 8'h00);
        exec(3'd1, 8'hC3);
        exec(3'd7, 8'h00);
        check("b2b_acc", acc_out, 8'h5A);
        check("b2b_cnt", stk_count, 0);
        exec(3'd1, 8'h6B);
        exec(3'd6, 8'h00);
        exec(3'd7, 8'h00);
        check("b2b2_acc", acc_out, 8'h6B);

        // Async reset mid-cycle with a POP pending
        exec(3'd1, 8'hAA);
        exec(3'd6, 8'h00);
        exec(3'd6, 8'h00);
        check("pre_rst_cnt", stk_count, 2);
        op = 3'd7; op_en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_acc", acc_out, 8'h00);
        check("arst_cnt", stk_count, 0);
        check("arst_empty", stk_empty, 1);
        @(posedge clk);
        #1;
        check("arst_hold_acc", acc_out, 8'h00);
        op_en = 1'b0; op = 3'd0;
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        check("post_rst_cnt", stk_count, 0);
        check("post_rst_err", stk_err, 0);
        exec(3'd7, 8'h00);
        check("post_rst_pop_err", stk_err, 1);
        check("post_rst_pop_acc", acc_out, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
